// File: rtl/time_ctrl.sv
// Time-of-day controller: 1 Hz prescaler, sec/min/hour counter chain and run/set FSM.
// Optional alarm comparator is built only when TIME_CTRL_ALARM_EN is defined.
module time_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [2:0] state,
  output logic       tick,
  output logic       alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_SET_HR     = 3'd1,
    ST_SET_MIN    = 3'd2
`ifdef TIME_CTRL_ALARM_EN
    ,
    ST_SET_AL_HR  = 3'd3,
    ST_SET_AL_MIN = 3'd4
`endif
  } state_t;

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    if (v == 6'd59) begin
      inc_mod60 = 6'd0;
    end else begin
      inc_mod60 = v + 6'd1;
    end
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    if (v == 5'd23) begin
      inc_mod24 = 5'd0;
    end else begin
      inc_mod24 = v + 5'd1;
    end
  endfunction

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [5:0]    sec_r, sec_nxt_s;
  logic [5:0]    min_r, min_nxt_s;
  logic [4:0]    hour_r, hour_nxt_s;
  logic          tick_r;
  logic          advance_s;
  logic          inc_ok_s;
  logic          enter_run_s;

  assign advance_s   = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
  // mode_pulse has priority over inc_pulse in the same cycle
  assign inc_ok_s    = inc_pulse && !mode_pulse;
  assign enter_run_s = mode_pulse && (state_r != ST_RUN) && (state_nxt_s == ST_RUN);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: mode_pulse walks the set states and back to RUN
  always_comb begin
    state_nxt_s = state_r;
    if (mode_pulse) begin
      case (state_r)
        ST_RUN:        state_nxt_s = ST_SET_HR;
        ST_SET_HR:     state_nxt_s = ST_SET_MIN;
`ifdef TIME_CTRL_ALARM_EN
        ST_SET_MIN:    state_nxt_s = ST_SET_AL_HR;
        ST_SET_AL_HR:  state_nxt_s = ST_SET_AL_MIN;
        ST_SET_AL_MIN: state_nxt_s = ST_RUN;
`else
        ST_SET_MIN:    state_nxt_s = ST_RUN;
`endif
        default:       state_nxt_s = ST_RUN;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Prescaler next value: counts only while staying in RUN, otherwise parked at 0
  always_comb begin
    presc_nxt_s = '0;
    if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
      if (advance_s) begin
        presc_nxt_s = '0;
      end else begin
        presc_nxt_s = presc_r + PW'(1);
      end
    end else begin
      presc_nxt_s = '0;
    end
  end

  // Time counter next values: run-mode cascade or set-mode increments
  always_comb begin
    sec_nxt_s  = sec_r;
    min_nxt_s  = min_r;
    hour_nxt_s = hour_r;
    if (advance_s) begin
      sec_nxt_s = inc_mod60(sec_r);
      if (sec_r == 6'd59) begin
        min_nxt_s = inc_mod60(min_r);
        if (min_r == 6'd59) begin
          hour_nxt_s = inc_mod24(hour_r);
        end else begin
          hour_nxt_s = hour_r;
        end
      end else begin
        min_nxt_s = min_r;
      end
    end else if (inc_ok_s) begin
      case (state_r)
        ST_SET_HR:  hour_nxt_s = inc_mod24(hour_r);
        ST_SET_MIN: min_nxt_s  = inc_mod60(min_r);
        default:    hour_nxt_s = hour_r;
      endcase
    end else begin
      sec_nxt_s = sec_r;
    end
    if (enter_run_s) begin
      sec_nxt_s = 6'd0;
    end else begin
      sec_nxt_s = sec_nxt_s;
    end
  end

  // Datapath registers; tick is suppressed when the advance coincides with leaving RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
      sec_r   <= 6'd0;
      min_r   <= 6'd0;
      hour_r  <= 5'd0;
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_nxt_s;
      sec_r   <= sec_nxt_s;
      min_r   <= min_nxt_s;
      hour_r  <= hour_nxt_s;
      tick_r  <= advance_s && (state_nxt_s == ST_RUN);
    end
  end

`ifdef TIME_CTRL_ALARM_EN
  logic [4:0] al_hour_r, al_hour_nxt_s;
  logic [5:0] al_min_r, al_min_nxt_s;
  logic       alarm_r, alarm_nxt_s;

  // Alarm setpoint edits and alarm flag: set on a matching minute rollover, cleared by any user pulse
  always_comb begin
    al_hour_nxt_s = al_hour_r;
    al_min_nxt_s  = al_min_r;
    alarm_nxt_s   = alarm_r;
    if (inc_ok_s) begin
      case (state_r)
        ST_SET_AL_HR:  al_hour_nxt_s = inc_mod24(al_hour_r);
        ST_SET_AL_MIN: al_min_nxt_s  = inc_mod60(al_min_r);
        default:       al_hour_nxt_s = al_hour_r;
      endcase
    end else begin
      al_hour_nxt_s = al_hour_r;
    end
    if (mode_pulse || inc_pulse) begin
      alarm_nxt_s = 1'b0;
    end else if (advance_s && (sec_nxt_s == 6'd0)) begin
      alarm_nxt_s = (hour_nxt_s == al_hour_r) && (min_nxt_s == al_min_r);
    end else begin
      alarm_nxt_s = alarm_r;
    end
  end

  // Alarm registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_hour_r <= 5'd0;
      al_min_r  <= 6'd0;
      alarm_r   <= 1'b0;
    end else begin
      al_hour_r <= al_hour_nxt_s;
      al_min_r  <= al_min_nxt_s;
      alarm_r   <= alarm_nxt_s;
    end
  end

  assign alarm = alarm_r;
`else
  assign alarm = 1'b0;
`endif

  assign sec   = sec_r;
  assign min   = min_r;
  assign hour  = hour_r;
  assign state = state_r;
  assign tick  = tick_r;

endmodule

// File: tb/tb_time_ctrl.sv
// Directed self-checking bench for time_ctrl with TICK_DIV=4.
module tb_time_ctrl;

  localparam int TD = 4;

  logic       clk;
  logic       rst_n;
  logic       mode_pulse;
  logic       inc_pulse;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [2:0] state;
  logic       tick;
  logic       alarm;

  int total;
  int bad;

`ifdef TIME_CTRL_ALARM_EN
  localparam logic EXP_AL = 1'b1;
`else
  localparam logic EXP_AL = 1'b0;
`endif

  time_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_pulse (mode_pulse),
    .inc_pulse  (inc_pulse),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .state      (state),
    .tick       (tick),
    .alarm      (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    mode_pulse = 1'b1;
    cyc();
    mode_pulse = 1'b0;
  endtask

  task automatic incs(input int n);
    inc_pulse = 1'b1;
    repeat (n) cyc();
    inc_pulse = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(hour), 32'(h));
    chk({tag, "_min"},  32'(min),  32'(m));
    chk({tag, "_sec"},  32'(sec),  32'(s));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    mode_pulse = 1'b0;
    inc_pulse = 1'b0;
    repeat (2) cyc();
    chk_time("rst", 0, 0, 0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);

    // Tick every TD cycles after release, sec counts 1,2,3
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("run_tick_c%0d", k), 32'(tick), ((k % TD) == 0) ? 32'd1 : 32'd0);
      chk($sformatf("run_sec_c%0d", k), 32'(sec), 32'(k / TD));
    end

    // Set 23:59 through the set states
    pulse_mode();
    chk("st_sethr", 32'(state), 32'd1);
    incs(23);
    chk("set_hour23", 32'(hour), 32'd23);
    chk("set_hr_notick", 32'(tick), 32'd0);
    mode_pulse = 1'b1;
    inc_pulse = 1'b1;
    cyc();
    mode_pulse = 1'b0;
    inc_pulse = 1'b0;
    chk("both_state", 32'(state), 32'd2);
    chk("both_hour", 32'(hour), 32'd23);
    incs(59);
    chk("set_min59", 32'(min), 32'd59);
    incs(1);
    chk_time("min_wrap", 23, 0, 3);
    chk("min_wrap_notick", 32'(tick), 32'd0);
    repeat (6) cyc();
    chk("set_idle_notick", 32'(tick), 32'd0);
    chk("set_idle_sec", 32'(sec), 32'd3);
    incs(59);
    chk("set_min59b", 32'(min), 32'd59);
`ifdef TIME_CTRL_ALARM_EN
    pulse_mode();
    chk("st_setalhr", 32'(state), 32'd3);
    pulse_mode();
    chk("st_setalmin", 32'(state), 32'd4);
    incs(1);
`endif
    pulse_mode();
    chk("back_run", 32'(state), 32'd0);
    chk_time("run_entry", 23, 59, 0);

    // 59 ticks to 23:59:59, then full rollover on the next one
    repeat (59 * TD) cyc();
    chk_time("pre_roll", 23, 59, 59);
    repeat (TD - 1) cyc();
    chk("pre_roll_notick", 32'(tick), 32'd0);
    cyc();
    chk("roll_tick", 32'(tick), 32'd1);
    chk_time("roll", 0, 0, 0);

    // Alarm at 00:01:00 (stays 0 without the alarm build)
    repeat (60 * TD - 1) cyc();
    chk("al_before", 32'(alarm), 32'd0);
    chk_time("al_before_t", 0, 0, 59);
    cyc();
    chk_time("al_time", 0, 1, 0);
    chk("al_rise", 32'(alarm), 32'(EXP_AL));
    repeat (5) cyc();
    chk("al_hold", 32'(alarm), 32'(EXP_AL));
    incs(1);
    chk("al_clear", 32'(alarm), 32'd0);

    // Go to 12:34:56, then reset asynchronously mid-count
    pulse_mode();
    incs(12);
    pulse_mode();
    incs(33);
`ifdef TIME_CTRL_ALARM_EN
    pulse_mode();
    pulse_mode();
`endif
    pulse_mode();
    chk("run_again", 32'(state), 32'd0);
    repeat (56 * TD) cyc();
    chk_time("t123456", 12, 34, 56);
    repeat (2) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_alarm", 32'(alarm), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (TD - 1) cyc();
    chk("post_rst_notick", 32'(tick), 32'd0);
    chk("post_rst_sec0", 32'(sec), 32'd0);
    cyc();
    chk("post_rst_tick", 32'(tick), 32'd1);
    chk("post_rst_sec1", 32'(sec), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_ctrl.md
# time_ctrl

Time-of-day controller that sequences a cascaded seconds (mod-60), minutes (mod-60) and hours (mod-24) counter chain from a free-running system clock. It contains a 1 Hz tick prescaler and a run/set state machine driven by two user pulses. Its outputs feed the display driver. Optionally, it provides a one-entry alarm comparator.

## Interface
- TICK_DIV, 50_000_000 — clk cycles per 1 s tick; legal range ≥ 2
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- mode_pulse  input  1  one-cycle synchronous pulse (debounced upstream); advances the state machine
- inc_pulse  input  1  one-cycle synchronous pulse; increments the field selected in a set state
- sec  output  6  seconds, 0..59
- min  output  6  minutes, 0..59
- hour  output  5  hours, 0..23
- state  output  3  current FSM state encoding
- tick  output  1  one-cycle pulse, high in the cycle a new sec value first appears
- alarm  output  1  alarm indication; tied 0 when ALARM_EN is undefined

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- States and encodings: RUN=0, SET_HR=1, SET_MIN=2, SET_AL_HR=3, SET_AL_MIN=4 (last two only with ALARM_EN).
- Transitions on mode_pulse:
  - RUN→SET_HR→SET_MIN→RUN.
  - With ALARM_EN: SET_MIN→SET_AL_HR→SET_AL_MIN→RUN.
- Prescaler: a counter 0..TICK_DIV-1 that counts only in RUN. It is held at 0 in every set state.
- Advance: a RUN cycle with prescaler==TICK_DIV-1 advances the time.
  - Advance increments sec. When sec==59 it wraps to 0 and carries to min.
  - min==59 wraps to 0 and carries to hour; hour==23 wraps to 0.
  - 23:59:59 → 00:00:00 on a single advance.
- SET_HR: inc_pulse increments hour mod 24.
- SET_MIN: inc_pulse increments min mod 60 with no carry into hour.
- SET_AL_HR / SET_AL_MIN: inc_pulse increments alarm_hour mod 24 / alarm_min mod 60.
- On the SET_MIN→RUN transition (and SET_AL_MIN→RUN), sec is cleared to 0. The prescaler restarts from 0.
- Simultaneous events:
  - mode_pulse and inc_pulse in the same cycle: mode_pulse wins and inc_pulse is ignored.
  - A RUN-state advance coinciding with mode_pulse: the advance still occurs and state moves to SET_HR.
- Reset mid-operation: all outputs, the prescaler and the alarm registers return to reset values immediately (asynchronous assertion). Operation resumes in RUN on the first edge after release.

## Timing
- Reset values: sec=0, min=0, hour=0, state=0 (RUN), tick=0, alarm=0, prescaler=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Advance latency: tick and the updated sec/min/hour appear on the edge after the cycle where prescaler==TICK_DIV-1.
- Tick period in RUN is exactly TICK_DIV cycles. The first tick after reset or after entering RUN comes TICK_DIV cycles after RUN is entered.
- inc_pulse and mode_pulse take effect on the next clock edge (1-cycle latency to outputs).
- tick is never asserted outside RUN.

## Configuration
- Macro: TIME_CTRL_ALARM_EN.
- Defined:
  - Adds 5-bit alarm_hour and 6-bit alarm_min registers (reset 0) and states 3/4.
  - alarm rises with the tick where the advance produces sec==0, hour==alarm_hour and min==alarm_min.
  - alarm stays high until the next minute change, or until any mode_pulse or inc_pulse, whichever comes first.
- Undefined:
  - States 3/4 do not exist and SET_MIN→RUN is direct.
  - alarm is constant 0; no alarm registers are built.

## Test plan
- TICK_DIV=4, reset then run for 12 cycles → tick high at cycles 4, 8, 12; sec = 1, 2, 3.
- Set the time to 23:59 through the SET states, return to RUN, wait 60 ticks → 23:59:59 → 00:00:00 in one tick.
- In SET_MIN with min=59, pulse inc_pulse → min=0, hour unchanged; the prescaler stays 0 and no tick occurs.
- mode_pulse and inc_pulse in the same cycle in SET_HR → state=SET_MIN, hour unchanged.
- Assert rst_n low mid-count at 12:34:56 → all outputs 0 asynchronously; after release the first tick arrives TICK_DIV cycles later.
- With TIME_CTRL_ALARM_EN, alarm set to 00:01 → alarm rises at 00:01:00 and clears on the following inc_pulse. Without the macro, the same stimulus leaves alarm=0 and mode_pulse in SET_MIN returns to RUN.
